sa_cache_ctrl: RTL and testbench
================================

# sa_cache_ctrl

Parametrised, synthesisable N-way set-associative cache tag/state controller with true-LRU replacement, write-back dirty tracking and hit/miss/write-back statistics. It accepts one address request per handshake, performs tag lookup and replacement, and reports hit/miss and the evicted dirty tag for the data-path and memory-side logic. It sits between the trace or CPU request source and the cache data array, and supersedes the single-way behavioural cache model.

## Interface
- ADD_SZ, 26, address width in bits.
- BLK_OFF_SZ, 6, block-offset bits (address[BLK_OFF_SZ-1:0]).
- IND_SZ, 9, index bits (address[BLK_OFF_SZ+IND_SZ-1:BLK_OFF_SZ]); N = 2**IND_SZ sets.
- A, 4, ways; power of two, 1..16. AGE_W = max(1, log2(A)).
- CNT_W, 32, statistics counter width.
- TAG_SZ, derived = ADD_SZ-IND_SZ-BLK_OFF_SZ (11 by default); tag = address[ADD_SZ-1:ADD_SZ-TAG_SZ].
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; transfer when req_valid & req_ready.
- req_addr  in  ADD_SZ  request address.
- req_wr  in  1  1 = write, 0 = read.
- clr_stats  in  1  synchronous clear of all statistics counters.
- resp_valid  out  1  one-cycle pulse: lookup result valid.
- resp_hit  out  1  1 = hit, 0 = miss.
- resp_way  out  AGE_W  way hit or filled.
- resp_evict  out  1  miss replaced a valid, dirty line (write-back required).
- resp_evict_tag  out  TAG_SZ  tag of written-back line; valid only when resp_evict=1.
- hits, misses, writebacks, tries  out  CNT_W  statistics.

## Operation
- Per-set, per-way state: valid, dirty, tag[TAG_SZ], age[AGE_W]. Ages within a set are always a permutation of 0..A-1 (0 = MRU, A-1 = LRU).
- FSM states: INIT, IDLE, LOOKUP.
- INIT: entered on rst; sweeps set 0..N-1, one set per cycle, clearing valid and dirty and loading age[w] = w. Moves to IDLE after set N-1. req_ready = 0.
- IDLE: req_ready = 1. On handshake, capture addr and wr; go to LOOKUP.
- LOOKUP: req_ready = 0. hit = any way with valid & tag match (at most one can match). Then:
  - Hit: way w = matching way; dirty[w] |= wr.
  - Miss: w = lowest-numbered invalid way; if none, w = the way with age A-1. resp_evict = valid[w] & dirty[w], resp_evict_tag = old tag[w]. Then load tag[w] = tag, valid[w] = 1, dirty[w] = wr.
  - LRU update (hit and miss): every way with age < age[w] increments; age[w] = 0.
  - Return to IDLE.
- Statistics: tries +1 per lookup; hits or misses +1; writebacks +1 when resp_evict. All counters saturate at 2**CNT_W-1. If clr_stats coincides with an increment, the clear wins (result 0).
- A = 1: the way is always the victim; ages stay 0.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_hit=0, resp_way=0, resp_evict=0, resp_evict_tag=0, all counters 0.
- After rst deasserts, INIT takes N cycles; req_ready rises in cycle N+1 (cycle 513 by default).
- Accept at edge k; resp_* registered at edge k+1, resp_valid high for exactly one cycle; req_ready high again after edge k+1. Sustained throughput: one request per 2 cycles.
- No response back-pressure; the consumer must sample resp_valid.
- resp_hit, resp_way, resp_evict and resp_evict_tag hold their values until the next response; resp_evict is cleared on a hit response.
- rst asserted in any state, including mid-LOOKUP: the in-flight request is dropped with no response and no counter update; FSM restarts INIT.
- Back-to-back requests to the same set see the state updated by the previous lookup.

## Test plan
- Reset: hold rst 2 cycles, release -> req_ready=0 for 512 cycles then 1; all outputs 0.
- Cold miss then hit: read 0x08140 (tag 1, set 5) -> miss, way 0, resp_evict=0; read 0x08155 -> hit, way 0; tries=2, hits=1, misses=1.
- LRU eviction: reads of tags 1..4 in set 5 (0x08140, 0x10140, 0x18140, 0x20140) fill ways 0..3; reread 0x08140 (hit); read 0x28140 -> miss, way 1 (tag 2 replaced), resp_evict=0.
- Dirty write-back: write 0x08140, then reads of tags 2..5 in set 5 -> the tag-5 request misses with resp_evict=1, resp_evict_tag=0x001; writebacks=1.
- clr_stats asserted in the same cycle a hit is counted -> hits=0, tries=0 next cycle; the next hit gives hits=1.
- Reset mid-LOOKUP: assert rst the cycle after a handshake -> no resp_valid pulse; counters 0; the previously filled line now misses after INIT.

Source files
------------

// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: N-way set-associative tag/state controller with true-LRU
// replacement, write-back dirty tracking and saturating statistics.
//
// state  | meaning
// INIT   | sweeping sets after reset: clear valid/dirty, ages = way number
// IDLE   | ready for a request
// LOOKUP | tag compare, victim selection, LRU update, response
module sa_cache_ctrl #(
  parameter  int ADD_SZ     = 26,
  parameter  int BLK_OFF_SZ = 6,
  parameter  int IND_SZ     = 9,
  parameter  int A          = 4,
  parameter  int CNT_W      = 32,
  localparam int AGE_W      = (A > 1) ? $clog2(A) : 1,
  localparam int TAG_SZ     = ADD_SZ - IND_SZ - BLK_OFF_SZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADD_SZ-1:0] req_addr,
  input  logic              req_wr,
  input  logic              clr_stats,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [AGE_W-1:0]  resp_way,
  output logic              resp_evict,
  output logic [TAG_SZ-1:0] resp_evict_tag,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  writebacks,
  output logic [CNT_W-1:0]  tries
);

  localparam int N = 2 ** IND_SZ;

  typedef enum logic [1:0] {INIT, IDLE, LOOKUP} state_t;

  state_t              state;
  logic [IND_SZ-1:0]   init_idx;
  logic [IND_SZ-1:0]   lk_idx;
  logic [TAG_SZ-1:0]   lk_tag;
  logic                lk_wr;

  logic                valid_mem [N][A];
  logic                dirty_mem [N][A];
  logic [TAG_SZ-1:0]   tag_mem   [N][A];
  logic [AGE_W-1:0]    age_mem   [N][A];

  logic                hit;
  logic [AGE_W-1:0]    hit_way;
  logic                inv_found;
  logic [AGE_W-1:0]    inv_way;
  logic [AGE_W-1:0]    lru_way;
  logic [AGE_W-1:0]    sel_way;
  logic [AGE_W-1:0]    sel_age;
  logic                victim_evict;
  logic [TAG_SZ-1:0]   victim_tag;

  // Block-offset bits select bytes in the data array only.
  logic unused_offset;
  assign unused_offset = ^req_addr[BLK_OFF_SZ-1:0];

  // Tag compare and victim choice for the captured request; scanning from the
  // top way down leaves the lowest-numbered invalid way selected.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = A - 1; w >= 0; w--) begin
      if (valid_mem[lk_idx][w] && tag_mem[lk_idx][w] == lk_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_mem[lk_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_mem[lk_idx][w] == AGE_W'(A - 1)) lru_way = AGE_W'(w);
    end
    sel_way      = hit ? hit_way : (inv_found ? inv_way : lru_way);
    sel_age      = age_mem[lk_idx][sel_way];
    victim_evict = !hit && valid_mem[lk_idx][sel_way] && dirty_mem[lk_idx][sel_way];
    victim_tag   = tag_mem[lk_idx][sel_way];
  end

  // Controller FSM, per-way state arrays and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT;
      init_idx       <= '0;
      lk_idx         <= '0;
      lk_tag         <= '0;
      lk_wr          <= 1'b0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        INIT: begin
          for (int w = 0; w < A; w++) begin
            valid_mem[init_idx][w] <= 1'b0;
            dirty_mem[init_idx][w] <= 1'b0;
            age_mem[init_idx][w]   <= AGE_W'(w);
          end
          init_idx <= init_idx + 1'b1;
          if (init_idx == IND_SZ'(N - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            lk_idx    <= req_addr[BLK_OFF_SZ+IND_SZ-1:BLK_OFF_SZ];
            lk_tag    <= req_addr[ADD_SZ-1:ADD_SZ-TAG_SZ];
            lk_wr     <= req_wr;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          for (int w = 0; w < A; w++) begin
            if (age_mem[lk_idx][w] < sel_age) age_mem[lk_idx][w] <= age_mem[lk_idx][w] + 1'b1;
          end
          age_mem[lk_idx][sel_way] <= '0;
          if (hit) begin
            dirty_mem[lk_idx][sel_way] <= dirty_mem[lk_idx][sel_way] | lk_wr;
          end else begin
            tag_mem[lk_idx][sel_way]   <= lk_tag;
            valid_mem[lk_idx][sel_way] <= 1'b1;
            dirty_mem[lk_idx][sel_way] <= lk_wr;
          end
          resp_valid <= 1'b1;
          resp_hit   <= hit;
          resp_way   <= sel_way;
          resp_evict <= victim_evict;
          if (victim_evict) resp_evict_tag <= victim_tag;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= INIT;
          init_idx  <= '0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Saturating statistics; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      hits       <= '0;
      misses     <= '0;
      writebacks <= '0;
      tries      <= '0;
    end else if (state == LOOKUP) begin
      tries <= sat_inc(tries);
      if (hit) hits <= sat_inc(hits);
      else     misses <= sat_inc(misses);
      if (victim_evict) writebacks <= sat_inc(writebacks);
    end
  end

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed bench for sa_cache_ctrl: expected responses queued at request time,
// checked by a monitor when resp_valid pulses.
module tb_sa_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [25:0] req_addr;
  logic        req_wr;
  logic        clr_stats;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        resp_evict;
  logic [10:0] resp_evict_tag;
  logic [31:0] hits, misses, writebacks, tries;

  typedef struct {
    logic        hit;
    logic [1:0]  way;
    logic        evict;
    logic [10:0] etag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sa_cache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wr(req_wr), .clr_stats(clr_stats),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
    .hits(hits), .misses(misses), .writebacks(writebacks), .tries(tries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int t, input int h, input int m, input int wb);
    chk({tag, "_tries"}, tries, t);
    chk({tag, "_hits"}, hits, h);
    chk({tag, "_misses"}, misses, m);
    chk({tag, "_writebacks"}, writebacks, wb);
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", resp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_way", resp_way, e.way);
        chk("resp_evict", resp_evict, e.evict);
        if (e.evict) chk("resp_evict_tag", resp_evict_tag, e.etag);
      end
    end
  end

  // Issue one request from a negedge; optionally pulse clr_stats during the
  // lookup cycle so it coincides with the counter update.
  task automatic do_req(input logic [25:0] a, input logic wr, input logic eh,
                        input logic [1:0] ew, input logic ee, input logic [10:0] et,
                        input bit clr);
    int n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", req_ready, 1'b1);
    req_addr  = a;
    req_wr    = wr;
    req_valid = 1'b1;
    e.hit = eh; e.way = ew; e.evict = ee; e.etag = et;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (clr) clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; clr_stats = 1'b0;

    // Reset: outputs zero, ready held low for 512 cycles of INIT.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_hit", resp_hit, 1'b0);
    chk("rst_resp_way", resp_way, 2'd0);
    chk("rst_resp_evict", resp_evict, 1'b0);
    chk("rst_resp_evict_tag", resp_evict_tag, 11'd0);
    chk_stats("rst", 0, 0, 0, 0);
    rst = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
    chk("init_cycles", n, 512);

    // Cold miss then hit in the same block.
    do_req(26'h08140, 1'b0, 1'b0, 2'd0, 1'b0, 11'd0, 1'b0);
    do_req(26'h08155, 1'b0, 1'b1, 2'd0, 1'b0, 11'd0, 1'b0);
    chk_stats("cold", 2, 1, 1, 0);

    // Fill set 5, touch tag 1, then tag 5 replaces LRU tag 2 in way 1.
    do_req(26'h10140, 1'b0, 1'b0, 2'd1, 1'b0, 11'd0, 1'b0);
    do_req(26'h18140, 1'b0, 1'b0, 2'd2, 1'b0, 11'd0, 1'b0);
    do_req(26'h20140, 1'b0, 1'b0, 2'd3, 1'b0, 11'd0, 1'b0);
    do_req(26'h08140, 1'b0, 1'b1, 2'd0, 1'b0, 11'd0, 1'b0);
    do_req(26'h28140, 1'b0, 1'b0, 2'd1, 1'b0, 11'd0, 1'b0);
    chk_stats("lru", 7, 2, 5, 0);

    // Dirty tag 1 ages out and is written back.
    do_req(26'h08140, 1'b1, 1'b1, 2'd0, 1'b0, 11'd0, 1'b0);
    do_req(26'h10140, 1'b0, 1'b0, 2'd2, 1'b0, 11'd0, 1'b0);
    do_req(26'h18140, 1'b0, 1'b0, 2'd3, 1'b0, 11'd0, 1'b0);
    do_req(26'h20140, 1'b0, 1'b0, 2'd1, 1'b0, 11'd0, 1'b0);
    do_req(26'h28140, 1'b0, 1'b0, 2'd0, 1'b1, 11'h001, 1'b0);
    chk_stats("wb", 12, 3, 9, 1);

    // Clear coinciding with a hit wins; the next hit counts from zero.
    do_req(26'h28140, 1'b0, 1'b1, 2'd0, 1'b0, 11'd0, 1'b1);
    chk_stats("clr", 0, 0, 0, 0);
    do_req(26'h20140, 1'b0, 1'b1, 2'd1, 1'b0, 11'd0, 1'b0);
    chk_stats("after_clr", 1, 1, 0, 0);

    // Reset during LOOKUP drops the request and wipes the cache.
    req_addr = 26'h20140; req_wr = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_stats("midrst", 0, 0, 0, 0);
    chk("midrst_resp_hit", resp_hit, 1'b0);
    chk("midrst_resp_way", resp_way, 2'd0);
    n = 0;
    while (req_ready !== 1'b1 && n < 700) begin n++; @(negedge clk); end
    chk("midrst_ready", req_ready, 1'b1);
    do_req(26'h20140, 1'b0, 1'b0, 2'd0, 1'b0, 11'd0, 1'b0);
    chk_stats("post_midrst", 1, 0, 1, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
